// File: rtl/xbus_pkg.sv
// rtl/xbus_pkg.sv - shared types and constants for the xbus arbiter
// Contents: FSM state encoding, master IDs, bus widths, master-ID increment helper.
package xbus_pkg;

    localparam int XBUS_ADDR_W = 22;
    localparam int XBUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        DRAIN = 2'd2
    } xbus_state_e;

    localparam logic [1:0] M_CPU  = 2'd0;
    localparam logic [1:0] M_DISK = 2'd1;
    localparam logic [1:0] M_SPY  = 2'd2;

    // Next master ID in round-robin order, wrapping M_SPY back to M_CPU.
    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == M_SPY) ? M_CPU : id + 2'd1;
    endfunction

endpackage

// File: rtl/xbus_arb_pick.sv
// rtl/xbus_arb_pick.sv - combinational winner picker for three xbus masters
// Ports: req[2:0] pending requests, last[1:0] last-granted master,
//        winner[1:0] selected master, valid set when any request is pending.
// Build option: XBUS_ARB_RR_EN selects round-robin; otherwise fixed m0>m1>m2.
module xbus_arb_pick
    import xbus_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       valid
);

`ifdef XBUS_ARB_RR_EN
    function automatic logic req_bit(input logic [2:0] r, input logic [1:0] id);
        case (id)
            M_CPU:   return r[0];
            M_DISK:  return r[1];
            default: return r[2];
        endcase
    endfunction

    // Search starts at the master after the last one granted and wraps
    // around, so the last-granted master is considered last.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        winner = M_CPU;
        found  = 1'b0;
        cand   = last;
        for (int k = 0; k < 3; k++) begin
            cand = next_id(cand);
            if (!found && req_bit(req, cand)) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        valid = found;
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        winner = M_CPU;
        if (req[0])      winner = M_CPU;
        else if (req[1]) winner = M_DISK;
        else if (req[2]) winner = M_SPY;
        valid = |req;
    end
`endif

endmodule

// File: rtl/xbus_arbiter.sv
// rtl/xbus_arbiter.sv - three-master xbus arbiter with delayed-ack sequencing and NXM timeout
// Ports: clk, reset (sync, active-high);
//        mN_req/mN_write/mN_addr/mN_data from masters N=0..2 (CPU, disk DMA, spy);
//        mN_ack/mN_nxm one-cycle completion pulses, m_dataout read data for the acked master;
//        xbus_req/xbus_write/xbus_addr/xbus_dataout to slaves;
//        xbus_datain/xbus_ack/xbus_decode ORed back from slaves.
// Build option: XBUS_ARB_RR_EN enables round-robin arbitration (default fixed m0>m1>m2).
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m0_req,
    input  logic                   m0_write,
    input  logic [XBUS_ADDR_W-1:0] m0_addr,
    input  logic [XBUS_DATA_W-1:0] m0_data,
    output logic                   m0_ack,
    output logic                   m0_nxm,
    input  logic                   m1_req,
    input  logic                   m1_write,
    input  logic [XBUS_ADDR_W-1:0] m1_addr,
    input  logic [XBUS_DATA_W-1:0] m1_data,
    output logic                   m1_ack,
    output logic                   m1_nxm,
    input  logic                   m2_req,
    input  logic                   m2_write,
    input  logic [XBUS_ADDR_W-1:0] m2_addr,
    input  logic [XBUS_DATA_W-1:0] m2_data,
    output logic                   m2_ack,
    output logic                   m2_nxm,
    output logic [XBUS_DATA_W-1:0] m_dataout,
    output logic                   xbus_req,
    output logic                   xbus_write,
    output logic [XBUS_ADDR_W-1:0] xbus_addr,
    output logic [XBUS_DATA_W-1:0] xbus_dataout,
    input  logic [XBUS_DATA_W-1:0] xbus_datain,
    input  logic                   xbus_ack,
    input  logic                   xbus_decode
);

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    xbus_state_e            state_q;
    logic [1:0]             grant_q;
    logic [1:0]             last_q;
    logic [7:0]             count_q;
    logic                   decoded_q;
    logic [2:0]             ack_q;
    logic [2:0]             nxm_q;
    logic [XBUS_DATA_W-1:0] dataout_q;

    logic [1:0]             pick_winner;
    logic                   pick_valid;
    logic [2:0]             grant_oh;

    logic                   g_write;
    logic [XBUS_ADDR_W-1:0] g_addr;
    logic [XBUS_DATA_W-1:0] g_data;
    logic                   in_bus;

    xbus_arb_pick u_pick (
        .req    ({m2_req, m1_req, m0_req}),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign grant_oh = 3'b001 << grant_q;

    always_comb begin
        g_write = m0_write;
        g_addr  = m0_addr;
        g_data  = m0_data;
        case (grant_q)
            M_DISK: begin
                g_write = m1_write;
                g_addr  = m1_addr;
                g_data  = m1_data;
            end
            M_SPY: begin
                g_write = m2_write;
                g_addr  = m2_addr;
                g_data  = m2_data;
            end
            default: ;
        endcase
    end

    assign in_bus       = (state_q == BUS);
    assign xbus_req     = in_bus;
    assign xbus_write   = in_bus & g_write;
    assign xbus_addr    = in_bus ? g_addr : '0;
    assign xbus_dataout = in_bus ? g_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= M_CPU;
            last_q    <= M_SPY;   // first round-robin search then starts at m0
            count_q   <= 8'd0;
            decoded_q <= 1'b0;
            ack_q     <= 3'b000;
            nxm_q     <= 3'b000;
            dataout_q <= '0;
        end else begin
            ack_q <= 3'b000;
            nxm_q <= 3'b000;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_winner;
                        last_q  <= pick_winner;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (xbus_decode) decoded_q <= 1'b1;
                    // A slave ack takes precedence over a timeout expiring in the same cycle.
                    if (xbus_ack) begin
                        dataout_q <= xbus_datain;
                        ack_q     <= grant_oh;
                        state_q   <= DRAIN;
                    end else if (!decoded_q && count_q == COUNT_LAST) begin
                        dataout_q <= '0;
                        ack_q     <= grant_oh;
                        nxm_q     <= grant_oh;
                        state_q   <= DRAIN;
                    end else if (count_q != 8'hff) begin
                        count_q <= count_q + 8'd1;
                    end
                end
                DRAIN: begin
                    // Slave acks linger after req drops; wait them out so they
                    // cannot be credited to the next grant.
                    if (!xbus_ack) begin
                        count_q   <= 8'd0;
                        decoded_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m2_ack    = ack_q[2];
    assign m0_nxm    = nxm_q[0];
    assign m1_nxm    = nxm_q[1];
    assign m2_nxm    = nxm_q[2];
    assign m_dataout = dataout_q;

endmodule
